// File: rtl/id_branch_pkg.sv
// Shared types and constants for the ID-stage branch resolver.
// Holds the ARM condition-code encoding, the resolver FSM states,
// the B/BL opcode field value and the NZCV flag bit positions.
package id_branch_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0,
      NE = 4'h1,
      CS = 4'h2,
      CC = 4'h3,
      MI = 4'h4,
      PL = 4'h5,
      VS = 4'h6,
      VC = 4'h7,
      HI = 4'h8,
      LS = 4'h9,
      GE = 4'hA,
      LT = 4'hB,
      GT = 4'hC,
      LE = 4'hD,
      AL = 4'hE,
      NV = 4'hF
   } condCode_e;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_FLAGS = 2'd1,
      REDIRECT   = 2'd2,
      SQUASH     = 2'd3
   } brState_e;

   localparam logic [2:0] BR_OPCODE = 3'b101;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Word offset sign-extended and scaled to bytes; the add wraps silently at 2^32.
   function automatic logic [31:0] branchTarget(input logic [31:0] pc, input logic [23:0] imm);
      return pc + {{6{imm[23]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator.
// Given the 4-bit condition field and the {N,Z,C,V} flags, reports whether
// the instruction's condition passes. AL always passes, NV never does.
module cond_check
   import id_branch_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n;
   logic z;
   logic c;
   logic v;

   assign n = nzcv[FLAG_N];
   assign z = nzcv[FLAG_Z];
   assign c = nzcv[FLAG_C];
   assign v = nzcv[FLAG_V];

   // Decode the condition field against the current flags.
   always_comb begin
      pass = 1'b0;
      case (condCode_e'(cond))
         EQ:      pass = z;
         NE:      pass = !z;
         CS:      pass = c;
         CC:      pass = !c;
         MI:      pass = n;
         PL:      pass = !n;
         VS:      pass = v;
         VC:      pass = !v;
         HI:      pass = c && !z;
         LS:      pass = !c || z;
         GE:      pass = (n == v);
         LT:      pass = (n != v);
         GT:      pass = !z && (n == v);
         LE:      pass = z || (n != v);
         AL:      pass = 1'b1;
         NV:      pass = 1'b0;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/id_branch_resolver.sv
// ID-stage branch resolver: IF/ID pipeline register plus B/BL resolution.
// Decodes the branch held in IF/ID, waits for valid flags when the condition
// needs them, redirects IF_Stage on a taken branch and invalidates the
// SQUASH_SLOTS wrong-path captures that follow.
// Optional feature: define BRANCH_LINK_EN to drive link_we/link_value for BL;
// without it bit 24 is ignored and the link outputs are tied to 0.
module id_branch_resolver
   import id_branch_pkg::*;
#(
   parameter int SQUASH_SLOTS = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic [31:0] pc_in,
   input  logic [31:0] Instruction_in,
   input  logic [3:0]  status_nzcv,
   input  logic        status_valid,
   output logic [31:0] pc_out,
   output logic [31:0] Instruction_out,
   output logic        valid_out,
   output logic        Branch_Tacken,
   output logic [31:0] Branch_Address,
   output logic        stall_req,
   output logic        link_we,
   output logic [31:0] link_value
);

   brState_e    state_q;
   brState_e    state_d;
   logic [1:0]  squashCnt_q;
   logic [1:0]  squashCnt_d;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        valid_q;
   logic [31:0] brAddr_q;

   condCode_e   condField;
   logic        isBranch;
   logic        needsFlags;
   logic        flagsReady;
   logic        evalState;
   logic        condPass;
   logic        waitFlags;
   logic        takeBranch;

   assign condField  = condCode_e'(instr_q[31:28]);
   assign isBranch   = valid_q && (instr_q[27:25] == BR_OPCODE);
   assign needsFlags = (condField != AL) && (condField != NV);
   assign flagsReady = !needsFlags || status_valid;
   assign evalState  = (state_q == RUN) || (state_q == WAIT_FLAGS);
   assign waitFlags  = evalState && isBranch && !flagsReady;
   assign takeBranch = evalState && isBranch && flagsReady && condPass;

   cond_check u_condCheck (
      .cond (instr_q[31:28]),
      .nzcv (status_nzcv),
      .pass (condPass)
   );

   // State and squash counter register; freeze is folded into the next-state logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         squashCnt_q <= 2'd0;
      end else begin
         state_q     <= state_d;
         squashCnt_q <= squashCnt_d;
      end
   end

   // Next-state logic: resolve the branch in IF/ID, then walk through redirect and squash.
   always_comb begin
      state_d     = state_q;
      squashCnt_d = squashCnt_q;
      if (!freeze) begin
         case (state_q)
            RUN, WAIT_FLAGS: begin
               if (waitFlags) begin
                  state_d = WAIT_FLAGS;
               end else if (takeBranch) begin
                  state_d = REDIRECT;
               end else begin
                  state_d = RUN;
               end
            end
            REDIRECT: begin
               squashCnt_d = 2'(SQUASH_SLOTS - 1);
               state_d     = (SQUASH_SLOTS == 1) ? RUN : SQUASH;
            end
            SQUASH: begin
               squashCnt_d = (squashCnt_q != 2'd0) ? (squashCnt_q - 2'd1) : 2'd0;
               if (squashCnt_q <= 2'd1) begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Moore redirect strobe, plus the stall request while a branch waits for its flags.
   always_comb begin
      Branch_Tacken = (state_q == REDIRECT);
      stall_req     = waitFlags;
   end

   // IF/ID register and redirect target; captures during redirect/squash are marked invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= 32'd0;
         instr_q  <= 32'd0;
         valid_q  <= 1'b0;
         brAddr_q <= 32'd0;
      end else if (!freeze) begin
         if (!waitFlags) begin
            pc_q    <= pc_in;
            instr_q <= Instruction_in;
            valid_q <= evalState;
         end
         if (takeBranch) begin
            brAddr_q <= branchTarget(pc_q, instr_q[23:0]);
         end
      end
   end

   assign pc_out          = pc_q;
   assign Instruction_out = instr_q;
   assign valid_out       = valid_q;
   assign Branch_Address  = brAddr_q;

`ifdef BRANCH_LINK_EN
   logic        linkPend_q;
   logic [31:0] linkValue_q;

   // Remember whether the taken branch was a BL and its return address for the redirect cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         linkPend_q  <= 1'b0;
         linkValue_q <= 32'd0;
      end else if (!freeze) begin
         linkPend_q <= takeBranch && instr_q[24];
         if (takeBranch) begin
            linkValue_q <= pc_q;
         end
      end
   end

   assign link_we    = (state_q == REDIRECT) && linkPend_q;
   assign link_value = link_we ? linkValue_q : 32'd0;
`else
   assign link_we    = 1'b0;
   assign link_value = 32'd0;
`endif

endmodule
